// File: rtl/sat_round_shift.sv
// Two-stage requantiser: arithmetic right shift with selectable rounding, then saturation to OUT_W.
// Keeps per-channel sticky clip flags and a saturating clip-event counter.
module sat_round_shift #(
    parameter int unsigned IN_W    = 40,
    parameter int unsigned OUT_W   = 16,
    parameter int unsigned SHIFT_W = 6,
    parameter int unsigned N_CH    = 4,
    parameter int unsigned CH_W    = 2,
    parameter int unsigned CNT_W   = 16
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [IN_W-1:0]    in_data,
    input  logic [CH_W-1:0]    in_ch,
    input  logic [SHIFT_W-1:0] shift,
    input  logic [1:0]         rnd_mode,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [OUT_W-1:0]   out_data,
    output logic [CH_W-1:0]    out_ch,
    output logic               out_sat,
    output logic [N_CH-1:0]    sat_sticky,
    output logic [CNT_W-1:0]   sat_cnt,
    input  logic               clr
);

    localparam int unsigned EXT_W  = IN_W + 1;
    localparam int unsigned SH_MAX = IN_W - 1;
    localparam int unsigned UP_W   = EXT_W - OUT_W + 1;

    typedef enum logic [1:0] {
        RND_TRUNC = 2'b00,
        RND_UP    = 2'b01,
        RND_EVEN  = 2'b10,
        RND_ALT   = 2'b11
    } rnd_e;

    logic                    s1_valid;
    logic signed [EXT_W-1:0] s1_val;
    logic [CH_W-1:0]         s1_ch;
    logic                    s2_free;

    assign s2_free  = !out_valid || out_ready;
    assign in_ready = !s1_valid || s2_free;

    // Clamp the shift so the rounding constant stays inside the extended word
    logic [SHIFT_W-1:0] sh;
    always_comb begin
        sh = shift;
        if (32'(shift) > SH_MAX) begin
            sh = SHIFT_W'(SH_MAX);
        end
    end

    // Round at IN_W+1 bits; shift 0 degenerates to the input in every mode
    logic signed [EXT_W-1:0] x;
    logic        [EXT_W-1:0] one_sh;
    logic        [EXT_W-1:0] half;
    logic        [EXT_W-1:0] mask;
    logic signed [EXT_W-1:0] floor_q;
    logic signed [EXT_W-1:0] up_q;
    logic signed [EXT_W-1:0] rnd_q;
    logic                    tie;

    always_comb begin
        x       = EXT_W'($signed(in_data));
        one_sh  = EXT_W'(1) << sh;
        half    = one_sh >> 1;
        mask    = one_sh - EXT_W'(1);
        floor_q = x >>> sh;
        up_q    = (x + $signed(half)) >>> sh;
        tie     = (EXT_W'(x) & mask) == half;
        rnd_q   = floor_q;
        case (rnd_e'(rnd_mode))
            RND_UP:   rnd_q = up_q;
            RND_EVEN: rnd_q = (tie && !floor_q[0]) ? floor_q : up_q;
            default:  rnd_q = floor_q;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s1_valid <= 1'b0;
            s1_val   <= '0;
            s1_ch    <= '0;
        end else if (in_ready) begin
            s1_valid <= in_valid;
            if (in_valid) begin
                s1_val <= rnd_q;
                s1_ch  <= in_ch;
            end
        end
    end

    // Fits when all bits above the output sign bit replicate the sign
    logic [UP_W-1:0]  upper;
    logic             fits;
    logic [OUT_W-1:0] sat_data;

    always_comb begin
        upper    = s1_val[EXT_W-1:OUT_W-1];
        fits     = (&upper) || !(|upper);
        sat_data = s1_val[OUT_W-1:0];
        if (!fits) begin
            sat_data = s1_val[EXT_W-1] ? {1'b1, {(OUT_W-1){1'b0}}}
                                       : {1'b0, {(OUT_W-1){1'b1}}};
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_valid <= 1'b0;
            out_data  <= '0;
            out_ch    <= '0;
            out_sat   <= 1'b0;
        end else if (s2_free) begin
            out_valid <= s1_valid;
            if (s1_valid) begin
                out_data <= sat_data;
                out_ch   <= s1_ch;
                out_sat  <= !fits;
            end
        end
    end

    // Stats count clipped samples on downstream acceptance; clr wins over a coincident event
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sat_sticky <= '0;
            sat_cnt    <= '0;
        end else if (clr) begin
            sat_sticky <= '0;
            sat_cnt    <= '0;
        end else if (out_valid && out_ready && out_sat) begin
            sat_sticky[out_ch] <= 1'b1;
            if (sat_cnt != '1) begin
                sat_cnt <= sat_cnt + CNT_W'(1);
            end
        end
    end

endmodule

// File: tb/tb_sat_round_shift.sv
// Bench for sat_round_shift: directed scenarios plus randomized traffic against an arithmetic model.
module tb_sat_round_shift;

    localparam int unsigned IN_W    = 40;
    localparam int unsigned OUT_W   = 16;
    localparam int unsigned SHIFT_W = 6;
    localparam int unsigned N_CH    = 4;
    localparam int unsigned CH_W    = 2;
    localparam int unsigned CNT_W   = 3;
    localparam int          CNT_MAX = (1 << CNT_W) - 1;

    logic               clk = 1'b0;
    logic               rst;
    logic               in_valid;
    logic               in_ready;
    logic [IN_W-1:0]    in_data;
    logic [CH_W-1:0]    in_ch;
    logic [SHIFT_W-1:0] shift;
    logic [1:0]         rnd_mode;
    logic               out_valid;
    logic               out_ready;
    logic [OUT_W-1:0]   out_data;
    logic [CH_W-1:0]    out_ch;
    logic               out_sat;
    logic [N_CH-1:0]    sat_sticky;
    logic [CNT_W-1:0]   sat_cnt;
    logic               clr;

    sat_round_shift #(
        .IN_W(IN_W), .OUT_W(OUT_W), .SHIFT_W(SHIFT_W),
        .N_CH(N_CH), .CH_W(CH_W), .CNT_W(CNT_W)
    ) dut (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data), .in_ch(in_ch),
        .shift(shift), .rnd_mode(rnd_mode),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
        .out_ch(out_ch), .out_sat(out_sat),
        .sat_sticky(sat_sticky), .sat_cnt(sat_cnt), .clr(clr)
    );

    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;

    typedef struct {
        logic [OUT_W-1:0] data;
        logic [CH_W-1:0]  ch;
        logic             sat;
        int               acc;
    } exp_t;

    exp_t            q[$];
    int              cyc;
    int              m_cnt;
    logic [N_CH-1:0] m_sticky;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=0x%0h expected=0x%0h t=%0t", name, act, exp, $time);
        end
    endtask

    // Reference: floor division by 2^s with the requested tie handling
    function automatic longint ref_round(input longint v, input int s_in, input logic [1:0] m);
        longint fl, hu, rem;
        int s;
        s = (s_in > int'(IN_W) - 1) ? int'(IN_W) - 1 : s_in;
        if (s == 0) return v;
        fl  = v >>> s;
        hu  = (v + (longint'(1) << (s - 1))) >>> s;
        rem = v - (fl << s);
        case (m)
            2'b01:   return hu;
            2'b10:   return ((rem * 2 == (longint'(1) << s)) && ((fl & 1) == 0)) ? fl : hu;
            default: return fl;
        endcase
    endfunction

    function automatic void ref_sat(input longint r, output logic [OUT_W-1:0] d, output logic s);
        longint hi, lo;
        hi = (longint'(1) << (OUT_W - 1)) - 1;
        lo = -(longint'(1) << (OUT_W - 1));
        s  = 1'b1;
        if (r > hi)      d = OUT_W'(hi);
        else if (r < lo) d = OUT_W'(lo);
        else begin
            d = OUT_W'(r);
            s = 1'b0;
        end
    endfunction

    // Per-cycle comparison and model update, sampled mid-cycle
    always @(negedge clk) begin
        logic ev;
        exp_t e;
        if (rst) begin
            q.delete();
            m_cnt    = 0;
            m_sticky = '0;
            cyc      = 0;
        end else begin
            ev = (q.size() > 0) && (cyc - q[0].acc >= 2);
            chk("out_valid", 64'(out_valid), 64'(ev));
            chk("in_ready", 64'(in_ready), 64'((q.size() < 2) || out_ready));
            if (out_valid && ev) begin
                chk("out_data", 64'(out_data), 64'(q[0].data));
                chk("out_ch", 64'(out_ch), 64'(q[0].ch));
                chk("out_sat", 64'(out_sat), 64'(q[0].sat));
            end
            chk("sat_cnt", 64'(sat_cnt), 64'(m_cnt));
            chk("sat_sticky", 64'(sat_sticky), 64'(m_sticky));
            if (clr) begin
                m_cnt    = 0;
                m_sticky = '0;
            end
            if (out_valid && out_ready && q.size() > 0) begin
                if (!clr && q[0].sat) begin
                    m_sticky[q[0].ch] = 1'b1;
                    if (m_cnt < CNT_MAX) m_cnt++;
                end
                void'(q.pop_front());
            end
            if (in_valid && in_ready) begin
                ref_sat(ref_round(longint'($signed(in_data)), int'(shift), rnd_mode), e.data, e.sat);
                e.ch  = in_ch;
                e.acc = cyc;
                q.push_back(e);
            end
            cyc++;
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic set_in(input logic v, input longint d, input int c, input int s, input int m);
        in_valid = v;
        in_data  = IN_W'(d);
        in_ch    = CH_W'(c);
        shift    = SHIFT_W'(s);
        rnd_mode = 2'(m);
    endtask

    task automatic send(input longint d, input int c, input int s, input int m);
        set_in(1'b1, d, c, s, m);
        step();
        set_in(1'b0, 0, 0, 0, 0);
    endtask

    longint lit_d[6] = '{-3, -3, -3, 5, 5, 7};
    int     lit_m[6] = '{0, 1, 2, 1, 2, 2};
    longint lit_e[6] = '{-2, -1, -2, 3, 2, 4};

    initial begin
        logic [OUT_W-1:0] d;
        logic             s;
        int               idx;
        int               guard;
        logic [63:0]      raw;

        rst = 1'b1; out_ready = 1'b1; clr = 1'b0;
        set_in(1'b0, 0, 0, 0, 0);

        // Pin the reference model with hand-computed values
        ref_sat(ref_round(98304, 1, 2'b00), d, s);
        chk("lit_clip_data", 64'(d), 64'h7FFF);
        chk("lit_clip_sat", 64'(s), 64'd1);
        for (int i = 0; i < 6; i++) begin
            chk("lit_round", 64'(ref_round(lit_d[i], 1, 2'(lit_m[i]))), 64'(lit_e[i]));
        end
        ref_sat(ref_round(-(longint'(1) << 39), 0, 2'b00), d, s);
        chk("lit_neg_min", 64'(d), 64'h8000);

        #1;
        chk("rst_in_ready", 64'(in_ready), 64'd1);
        chk("rst_out_valid", 64'(out_valid), 64'd0);
        chk("rst_out_data", 64'(out_data), 64'd0);
        chk("rst_out_sat", 64'(out_sat), 64'd0);
        chk("rst_sat_cnt", 64'(sat_cnt), 64'd0);
        repeat (3) step();
        rst = 1'b0;
        step();

        // Clip on channel 1
        send(98304, 1, 1, 0);
        repeat (3) step();
        chk("t1_sat_cnt", 64'(sat_cnt), 64'd1);
        chk("t1_sticky", 64'(sat_sticky), 64'b0010);

        // Rounding modes back to back
        for (int i = 0; i < 6; i++) begin
            set_in(1'b1, lit_d[i], i % 4, 1, lit_m[i]);
            step();
        end
        set_in(1'b0, 0, 0, 0, 0);
        repeat (3) step();

        // Counter saturation and most-negative input
        for (int i = 0; i < 9; i++) begin
            set_in(1'b1, (i % 2 == 0) ? longint'(1) << 30 : -(longint'(1) << 39), i % 4, 0, 0);
            step();
        end
        set_in(1'b0, 0, 0, 0, 0);
        repeat (3) step();
        chk("t4_cnt_hold", 64'(sat_cnt), 64'(CNT_MAX));

        // clr coincident with a clipping transfer on ch2, then a clip on ch1
        send(longint'(1) << 20, 2, 0, 0);
        step();
        clr = 1'b1;
        chk("t5_out_valid", 64'(out_valid), 64'd1);
        step();
        clr = 1'b0;
        chk("t5_cnt", 64'(sat_cnt), 64'd0);
        chk("t5_sticky", 64'(sat_sticky), 64'd0);
        send(-(longint'(1) << 20), 1, 0, 0);
        repeat (3) step();
        chk("t5_sticky_ch1", 64'(sat_sticky), 64'b0010);

        // Backpressure: only two samples fit while the output is stalled
        out_ready = 1'b0;
        idx = 0;
        set_in(1'b1, 100, 0, 0, 0);
        for (int i = 0; i < 5; i++) begin
            if (in_valid && in_ready) idx++;
            step();
            if (idx < 4) set_in(1'b1, 100 + idx, idx, 0, 0);
            else set_in(1'b0, 0, 0, 0, 0);
        end
        chk("t3_accepted", 64'(idx), 64'd2);
        chk("t3_in_ready", 64'(in_ready), 64'd0);
        out_ready = 1'b1;
        guard = 0;
        while (idx < 4 && guard < 20) begin
            if (in_ready) idx++;
            step();
            if (idx < 4) set_in(1'b1, 100 + idx, idx, 0, 0);
            else set_in(1'b0, 0, 0, 0, 0);
            guard++;
        end
        chk("t3_all_accepted", 64'(idx), 64'd4);
        repeat (4) step();

        // Asynchronous reset with samples in flight
        send(1 << 20, 3, 0, 0);
        send(7, 2, 0, 0);
        #2;
        chk("t6_pre_valid", 64'(out_valid), 64'd1);
        rst = 1'b1;
        #1;
        chk("t6_async_valid", 64'(out_valid), 64'd0);
        chk("t6_async_ready", 64'(in_ready), 64'd1);
        step();
        rst = 1'b0;
        chk("t6_cnt", 64'(sat_cnt), 64'd0);
        chk("t6_sticky", 64'(sat_sticky), 64'd0);
        send(9, 1, 1, 1);
        step();
        chk("t6_latency", 64'(out_valid), 64'd1);
        chk("t6_data", 64'(out_data), 64'd5);
        repeat (2) step();

        // Randomized traffic with backpressure and occasional clears
        for (int i = 0; i < 3000; i++) begin
            raw = {$urandom(), $urandom()};
            raw = 64'($signed(raw[IN_W-1:0]) >>> $urandom_range(0, IN_W - 1));
            set_in($urandom_range(0, 3) != 0, longint'(raw), $urandom_range(0, N_CH - 1),
                   $urandom_range(0, 63), $urandom_range(0, 3));
            out_ready = $urandom_range(0, 9) < 7;
            clr       = $urandom_range(0, 49) == 0;
            step();
        end
        set_in(1'b0, 0, 0, 0, 0);
        out_ready = 1'b1;
        clr       = 1'b0;
        repeat (5) step();
        chk("drain_empty", 64'(q.size()), 64'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
